// File: rtl/fetch_sequencer.sv
// Instruction fetch / PC sequencer with MIPS branch delay slot and halt-on-jump-to-zero.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        exec_done,
    input  logic        jumptrue,
    input  logic        branchtrue,
    input  logic        jrtrue,
    input  logic [31:0] rs_data,
    output logic        active,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

    state_t      state;
    logic [31:0] redirect;
    logic        delay_pending;
    logic [31:0] pc4;
    logic [31:0] target;
    logic        redir_any;

    assign pc4       = pc + 32'd4;
    assign link_addr = pc + 32'd8;
    assign redir_any = jrtrue | jumptrue | branchtrue;

    always_comb begin
        target = 32'd0;
        if (jrtrue)
            target = rs_data;
        else if (jumptrue)
            target = {pc4[31:28], inst[25:0], 2'b00};
        else if (branchtrue)
            target = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
`ifndef FETCH_ALIGN_CHECK_EN
        target[1:0] = 2'b00;
`endif
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= RESET_VECTOR;
            address       <= RESET_VECTOR;
            read          <= 1'b0;
            inst          <= 32'd0;
            inst_valid    <= 1'b0;
            active        <= 1'b1;
            delay_pending <= 1'b0;
            redirect      <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    read    <= 1'b1;
                    address <= pc;
                end
                FETCH: begin
                    if (!waitrequest) begin
                        inst       <= readdata;
                        read       <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        inst_valid <= 1'b0;
                        if (!delay_pending) begin
                            if (redir_any) begin
                                redirect      <= target;
                                delay_pending <= 1'b1;
                            end
                            pc      <= pc4;
                            address <= pc4;
                            read    <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            // delay slot retires: its own redirect inputs are ignored
                            delay_pending <= 1'b0;
                            pc            <= redirect;
`ifdef FETCH_ALIGN_CHECK_EN
                            if (redirect[1:0] != 2'b00) begin
                                fault_q <= 1'b1;
                                active  <= 1'b0;
                                state   <= HALTED;
                            end else
`endif
                            if (redirect == 32'd0) begin
                                active <= 1'b0;
                                state  <= HALTED;
                            end else begin
                                address <= redirect;
                                read    <= 1'b1;
                                state   <= FETCH;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, wait states, delay slots,
// halt, PC wrap, alignment handling and reset mid-fetch.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        exec_done;
    logic        jumptrue;
    logic        branchtrue;
    logic        jrtrue;
    logic [31:0] rs_data;
    logic        active;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RV = 32'hBFC00000;

    fetch_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read),
        .waitrequest(waitrequest), .readdata(readdata), .inst(inst),
        .inst_valid(inst_valid), .pc(pc), .link_addr(link_addr),
        .exec_done(exec_done), .jumptrue(jumptrue), .branchtrue(branchtrue),
        .jrtrue(jrtrue), .rs_data(rs_data), .active(active),
        .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h10000003;  // beq, imm=3
            32'hBFC00004: return 32'h08000040;  // j 0x40
            32'hBFC00010: return 32'h08000040;  // j 0x40
            32'hB0000100: return 32'h02000008;  // jr $16
            32'hB0000104: return 32'h24020001;  // addiu
            default:      return 32'h00000000;
        endcase
    endfunction

    // garbage while stalled so only the completion-cycle word may be captured
    assign readdata = waitrequest ? 32'hDEADBEEF : mem_word(address);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_read"}, read, 0);
        chk({tag, "_addr"}, address, RV);
        chk({tag, "_pc"}, pc, RV);
        chk({tag, "_inst"}, inst, 0);
        chk({tag, "_valid"}, inst_valid, 0);
        chk({tag, "_active"}, active, 1);
        chk({tag, "_fault"}, fetch_fault, 0);
    endtask

    task automatic do_reset();
        reset = 0; waitrequest = 0; exec_done = 0;
        jumptrue = 0; branchtrue = 0; jrtrue = 0; rs_data = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1;
    endtask

    task automatic step_fetch(input int ws, input logic [31:0] ea);
        int n = 0;
        while (read !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_read", read, 1);
        chk("fetch_addr", address, ea);
        waitrequest = 1;
        for (int i = 0; i < ws; i++) begin
            @(negedge clk);
            chk("wait_read", read, 1);
            chk("wait_addr", address, ea);
        end
        waitrequest = 0;
        @(negedge clk);
        chk("inst_valid", inst_valid, 1);
        chk("exec_pc", pc, ea);
        chk("exec_inst", inst, mem_word(ea));
    endtask

    task automatic exec(input logic j, input logic br, input logic jr, input logic [31:0] rs);
        exec_done = 1; jumptrue = j; branchtrue = br; jrtrue = jr; rs_data = rs;
        @(negedge clk);
        exec_done = 0; jumptrue = 0; branchtrue = 0; jrtrue = 0; rs_data = 0;
        chk("valid_fall", inst_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // sequential fetch, 3 wait states on the first word
        do_reset();
        step_fetch(3, 32'hBFC00000);
        exec(0, 0, 0, 0);
        step_fetch(0, 32'hBFC00004);
        exec(0, 0, 0, 0);
        step_fetch(0, 32'hBFC00008);
        exec(0, 0, 0, 0);

        // branch with delay slot; J in delay slot ignored; J, then JR to 0 halts
        do_reset();
        step_fetch(0, 32'hBFC00000);
        chk("link_addr", link_addr, 32'hBFC00008);
        exec(0, 1, 0, 0);
        step_fetch(0, 32'hBFC00004);
        exec(1, 0, 0, 0);
        step_fetch(0, 32'hBFC00010);
        exec(1, 0, 0, 0);
        step_fetch(0, 32'hBFC00014);
        exec(0, 0, 0, 0);
        step_fetch(0, 32'hB0000100);
        exec(0, 0, 1, 32'h0);
        step_fetch(0, 32'hB0000104);
        exec(0, 0, 0, 0);
        chk("halt_active", active, 0);
        chk("halt_read", read, 0);
        chk("halt_pc", pc, 32'h0);
        repeat (3) @(negedge clk);
        chk("halt_stay_read", read, 0);
        chk("halt_stay_valid", inst_valid, 0);
        chk("halt_stay_active", active, 0);

        // sequential wrap to 0 keeps running
        do_reset();
        step_fetch(0, 32'hBFC00000);
        exec(0, 0, 1, 32'hFFFFFFFC);
        step_fetch(0, 32'hBFC00004);
        exec(0, 0, 0, 0);
        step_fetch(0, 32'hFFFFFFFC);
        exec(0, 0, 0, 0);
        step_fetch(0, 32'h00000000);
        chk("wrap_active", active, 1);
        exec(0, 0, 0, 0);

        // misaligned JR target
        do_reset();
        step_fetch(0, 32'hBFC00000);
        exec(0, 0, 1, 32'h00400002);
        step_fetch(0, 32'hBFC00004);
        exec(0, 0, 0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("align_fault", fetch_fault, 1);
        chk("align_active", active, 0);
        chk("align_pc", pc, 32'h00400002);
        chk("align_read", read, 0);
`else
        chk("align_fault", fetch_fault, 0);
        step_fetch(0, 32'h00400000);
        exec(0, 0, 0, 0);
`endif

        // reset asserted mid-fetch
        do_reset();
        step_fetch(0, 32'hBFC00000);
        exec(0, 0, 0, 0);
        chk("midfetch_read", read, 1);
        waitrequest = 1;
        reset = 0;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1;
        waitrequest = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch and PC sequencing stage that sits directly upstream of `control_signals`. It owns the program counter, fetches one instruction word at a time over the wait-request memory bus, and presents it as `inst`. It then consumes the downstream jump/branch decisions to redirect the PC, honouring the MIPS branch delay slot, and stops the core when control transfers to address 0.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'hBFC00000: PC loaded on reset.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `address`  out  32  instruction fetch byte address.
- `read`  out  1  fetch request.
- `waitrequest`  in  1  memory stall; the transfer completes on a cycle where `read`=1 and `waitrequest`=0.
- `readdata`  in  32  fetched instruction word.
- `inst`  out  32  current instruction, held stable while `inst_valid`=1.
- `inst_valid`  out  1  `inst` is executing.
- `pc`  out  32  address of `inst`.
- `link_addr`  out  32  `pc`+8; return address for JAL, JALR, BGEZAL and BLTZAL.
- `exec_done`  in  1  downstream has finished the current instruction (the `endi` equivalent).
- `jumptrue`, `branchtrue`, `jrtrue`  in  1 each  redirect decisions for the current `inst`.
- `rs_data`  in  32  register rs value, used as the JR/JALR target.
- `active`  out  1  core running; 0 once halted.
- `fetch_fault`  out  1  misaligned redirect detected (see Configuration).

## Operation
- States: IDLE, FETCH, EXEC, HALTED.
- Reset: state=IDLE, `pc`=`RESET_VECTOR`, `address`=`RESET_VECTOR`, `read`=0, `inst`=0, `inst_valid`=0, `active`=1, `fetch_fault`=0, `delay_pending`=0, `redirect`=0.
- IDLE -> FETCH unconditionally on the first cycle out of reset.
- FETCH:
  - `read`=1, with `address`=`pc` held constant while `waitrequest`=1.
  - On completion, `inst`<=`readdata` and state -> EXEC.
- EXEC: `inst_valid`=1. Redirect inputs and `exec_done` are sampled only in this state.
- On `exec_done` in EXEC, target selection:
  - `jrtrue`: target = `rs_data`.
  - `jumptrue`: target = {(`pc`+4)[31:28], `inst`[25:0], 2'b00}.
  - `branchtrue`: target = `pc`+4 + (sign-extended `inst`[15:0] << 2).
  - Priority jrtrue > jumptrue > branchtrue.
- Normal instruction (`delay_pending`=0):
  - If any redirect input is asserted: `redirect`<=target and `delay_pending`<=1.
  - Next `pc`=`pc`+4; state -> FETCH.
- Delay-slot instruction (`delay_pending`=1):
  - Next `pc`=`redirect` and `delay_pending`<=0.
  - Redirect inputs asserted by the delay-slot instruction are ignored.
  - If `redirect`==0: state -> HALTED, otherwise -> FETCH.
- HALTED: `active`=0, `read`=0, `inst_valid`=0. Only reset exits this state.
- Arithmetic is 32-bit modulo; `pc`+4 wraps from FFFFFFFC to 00000000. A sequential wrap to 0 does not halt; only a redirect to 0 does.

## Timing
- Minimum 2 cycles per instruction: FETCH with `waitrequest`=0, then EXEC with `exec_done`=1.
- Each `waitrequest`=1 cycle adds one cycle in FETCH.
- `inst_valid` rises the cycle after fetch completion and falls the cycle after `exec_done`.
- `link_addr` and `pc` are valid throughout EXEC.
- Reset asserted mid-fetch: `read` drops on the next edge. The bus must tolerate an abandoned request.
- `exec_done` held high on entry to EXEC is legal. The instruction then occupies exactly one EXEC cycle.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect target with bits [1:0]≠0 is detected when the delay slot completes.
  - The block sets `fetch_fault`=1 and enters HALTED, with `pc` holding the faulting target.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - Target bits [1:0] are forced to 0.
  - `fetch_fault` is tied to 0.

## Test plan
- Sequential fetch: reset released, `waitrequest`=0 throughout, `exec_done`=1 in EXEC -> fetch addresses BFC00000, BFC00004, BFC00008, with `inst_valid` every other cycle.
- Wait states: `waitrequest`=1 for 3 cycles on the first fetch -> `address`/`read` stable for 4 cycles; `inst` equals the `readdata` of the completion cycle.
- Branch with delay slot: BEQ at BFC00000, imm=3, `branchtrue`=1 -> next fetches are BFC00004 then BFC00010.
- Halt: JR with `rs_data`=0 -> delay slot at `pc`+4 executes, then `active`=0 and no further `read`.
- Delay-slot branch: J in the delay slot with `jumptrue`=1 -> ignored; the PC goes to the first target.
- Reset mid-fetch, plus alignment fault:
  - `reset`=0 during FETCH -> all outputs return to reset values on the next edge.
  - With the macro defined, JR `rs_data`=32'h00400002 -> after the delay slot, `fetch_fault`=1 and `active`=0.
